// File: rtl/bmstu_spi_pkg.sv
// Shared definitions for the bmstu SPI target: FSM state encoding and
// default opcode values used as parameter defaults by bmstu_spi_target.
package bmstu_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WDATA,
      ST_DUMMY,
      ST_RDATA,
      ST_IGNORE
   } spi_state_t;

   localparam logic [7:0]  SPI_CMD_WRITE  = 8'h55;
   localparam logic [7:0]  SPI_CMD_READ   = 8'h0B;
   localparam logic [7:0]  SPI_CMD_STATUS = 8'h05;
   localparam int unsigned SPI_STATUS_W   = 8;

endpackage

// File: rtl/bmstu_spi_sync.sv
// Two-flop synchroniser for an asynchronous pin, with single-cycle
// rise/fall pulses derived from the synchronised level.
module bmstu_spi_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic meta;
   logic q_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
         q_d  <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
         q_d  <= q;
      end
   end

   assign rise = q & ~q_d;
   assign fall = ~q & q_d;

endmodule

// File: rtl/bmstu_spi_target.sv
// SPI mode-0 target decoding cmd/addr/data frames into register-bus strobes.
// Define SPI_STATUS_EN to add the CMD_STATUS read of sticky error bits and write count.
module bmstu_spi_target
   import bmstu_spi_pkg::*;
#(
   parameter int unsigned      CMD_W      = 8,
   parameter int unsigned      ADDR_W     = 24,
   parameter int unsigned      DATA_W     = 32,
   parameter int unsigned      DUMMY_W    = 8,
   parameter logic [CMD_W-1:0] CMD_WRITE  = CMD_W'(SPI_CMD_WRITE),
   parameter logic [CMD_W-1:0] CMD_READ   = CMD_W'(SPI_CMD_READ),
   parameter logic [CMD_W-1:0] CMD_STATUS = CMD_W'(SPI_CMD_STATUS)
)(
   input  logic              clk_in,
   input  logic              reset_in_neg,
   input  logic              spi_sck_in,
   input  logic              spi_cs_in,
   input  logic              spi_copi_in,
   output logic              spi_cipo_out,
   output logic              wr_en_out,
   output logic [ADDR_W-1:0] wr_address_out,
   output logic [DATA_W-1:0] wr_data_out,
   output logic              rd_en_out,
   output logic [ADDR_W-1:0] rd_address_out,
   input  logic [DATA_W-1:0] rd_data_in,
   output logic              frame_err_out
);

   localparam int unsigned MAX_AB = (CMD_W > ADDR_W) ? CMD_W : ADDR_W;
   localparam int unsigned MAX_CD = (DATA_W > DUMMY_W) ? DATA_W : DUMMY_W;
   localparam int unsigned MAX_W  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned CNT_W  = $clog2(MAX_W + 1);

   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_W - 1);
   localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_W - 1);
`ifdef SPI_STATUS_EN
   localparam logic [CNT_W-1:0] STAT_LAST  = CNT_W'(SPI_STATUS_W - 1);
   localparam bit               STATUS_EN  = 1'b1;
`else
   localparam bit               STATUS_EN  = 1'b0;
`endif

   logic sck_level_unused, sck_rise, sck_fall;
   logic cs_q, cs_rise, cs_fall;
   logic copi_q, copi_rise_unused, copi_fall_unused;

   bmstu_spi_sync u_sck_sync  (.clk(clk_in), .rst_n(reset_in_neg), .d(spi_sck_in),
                               .q(sck_level_unused), .rise(sck_rise), .fall(sck_fall));
   bmstu_spi_sync u_cs_sync   (.clk(clk_in), .rst_n(reset_in_neg), .d(spi_cs_in),
                               .q(cs_q), .rise(cs_rise), .fall(cs_fall));
   bmstu_spi_sync u_copi_sync (.clk(clk_in), .rst_n(reset_in_neg), .d(spi_copi_in),
                               .q(copi_q), .rise(copi_rise_unused), .fall(copi_fall_unused));

   spi_state_t        state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CMD_W-1:0]  cmd_sr;
   logic [ADDR_W-1:0] addr_sr;
   logic [DATA_W-1:0] data_sr;
   logic [DATA_W-1:0] rd_sr;
   logic              rd_pend;
   logic              rd_cap;
`ifdef SPI_STATUS_EN
   logic              rd_is_status;
   logic              abort_sticky;
   logic              unknown_sticky;
   logic [5:0]        wr_count;
`endif

   logic              sck_rise_v;
   logic [CNT_W-1:0]  rdata_last;
   logic [CNT_W-1:0]  field_last;
   logic              last_bit;
   logic [CMD_W-1:0]  cmd_next;
   logic [ADDR_W-1:0] addr_next;
   logic [DATA_W-1:0] data_next;
   logic              cmd_is_wr, cmd_is_rd, cmd_is_stat, cmd_unknown;
   logic              complete_now, abort_now;

`ifdef SPI_STATUS_EN
   assign rdata_last = rd_is_status ? STAT_LAST : DATA_LAST;
`else
   assign rdata_last = DATA_LAST;
`endif

   // A rising edge that coincides with CS falling still belongs to the frame.
   assign sck_rise_v = sck_rise & (cs_q | cs_fall);

   always_comb begin
      field_last = '0;
      case (state)
         ST_CMD:   field_last = CMD_LAST;
         ST_ADDR:  field_last = ADDR_LAST;
         ST_WDATA: field_last = DATA_LAST;
         ST_DUMMY: field_last = DUMMY_LAST;
         ST_RDATA: field_last = rdata_last;
         default:  field_last = '0;
      endcase
   end

   assign last_bit     = sck_rise_v && (bit_cnt == field_last);
   assign cmd_next     = {cmd_sr[CMD_W-2:0], copi_q};
   assign addr_next    = {addr_sr[ADDR_W-2:0], copi_q};
   assign data_next    = {data_sr[DATA_W-2:0], copi_q};
   assign cmd_is_wr    = (cmd_next == CMD_WRITE);
   assign cmd_is_rd    = (cmd_next == CMD_READ);
   assign cmd_is_stat  = (cmd_next == CMD_STATUS);
   assign cmd_unknown  = !(cmd_is_wr || cmd_is_rd || (STATUS_EN && cmd_is_stat));
   assign complete_now = last_bit && (state == ST_WDATA || state == ST_RDATA);
   // An unknown command already reported its error, so a CS drop on that edge is not a second abort.
   assign abort_now    = cs_fall && (state != ST_IDLE) && (state != ST_IGNORE) && !complete_now
                         && !((state == ST_CMD) && last_bit && cmd_unknown);

   always_ff @(posedge clk_in or negedge reset_in_neg) begin
      if (!reset_in_neg) begin
         state          <= ST_IDLE;
         bit_cnt        <= '0;
         cmd_sr         <= '0;
         addr_sr        <= '0;
         data_sr        <= '0;
         rd_sr          <= '0;
         rd_pend        <= 1'b0;
         rd_cap         <= 1'b0;
         spi_cipo_out   <= 1'b0;
         wr_en_out      <= 1'b0;
         wr_address_out <= '0;
         wr_data_out    <= '0;
         rd_en_out      <= 1'b0;
         rd_address_out <= '0;
         frame_err_out  <= 1'b0;
`ifdef SPI_STATUS_EN
         rd_is_status   <= 1'b0;
         abort_sticky   <= 1'b0;
         unknown_sticky <= 1'b0;
         wr_count       <= '0;
`endif
      end else begin
         wr_en_out     <= 1'b0;
         frame_err_out <= 1'b0;
         rd_en_out     <= rd_pend;
         rd_pend       <= 1'b0;
         rd_cap        <= rd_en_out;

         if (state == ST_RDATA) begin
            if (sck_fall && cs_q) begin
               spi_cipo_out <= rd_sr[DATA_W-1];
               rd_sr        <= {rd_sr[DATA_W-2:0], 1'b0};
            end
         end else begin
            spi_cipo_out <= 1'b0;
         end

         if (rd_cap)
            rd_sr <= rd_data_in;

         if (sck_rise_v) begin
            bit_cnt <= bit_cnt + 1'b1;
            case (state)
               ST_CMD: begin
                  cmd_sr <= cmd_next;
                  if (last_bit) begin
                     bit_cnt <= '0;
                     if (cmd_is_wr || cmd_is_rd) begin
                        state <= ST_ADDR;
                     end
`ifdef SPI_STATUS_EN
                     else if (cmd_is_stat) begin
                        state        <= ST_DUMMY;
                        rd_is_status <= 1'b1;
                        rd_sr        <= {abort_sticky, unknown_sticky, wr_count,
                                         {(DATA_W - SPI_STATUS_W){1'b0}}};
                     end
`endif
                     else begin
                        state         <= ST_IGNORE;
                        frame_err_out <= 1'b1;
`ifdef SPI_STATUS_EN
                        unknown_sticky <= 1'b1;
`endif
                     end
                  end
               end
               ST_ADDR: begin
                  addr_sr <= addr_next;
                  if (last_bit) begin
                     bit_cnt <= '0;
                     if (cmd_sr == CMD_WRITE) begin
                        state <= ST_WDATA;
                     end else begin
                        state          <= ST_DUMMY;
                        rd_address_out <= addr_next;
                        rd_pend        <= 1'b1;
                     end
                  end
               end
               ST_WDATA: begin
                  data_sr <= data_next;
                  if (last_bit) begin
                     bit_cnt        <= '0;
                     state          <= ST_IGNORE;
                     wr_address_out <= addr_sr;
                     wr_data_out    <= data_next;
                     wr_en_out      <= 1'b1;
`ifdef SPI_STATUS_EN
                     wr_count       <= wr_count + 1'b1;
`endif
                  end
               end
               ST_DUMMY: begin
                  if (last_bit) begin
                     bit_cnt <= '0;
                     state   <= ST_RDATA;
                  end
               end
               ST_RDATA: begin
                  if (last_bit) begin
                     bit_cnt <= '0;
                     state   <= ST_IGNORE;
`ifdef SPI_STATUS_EN
                     if (rd_is_status) begin
                        abort_sticky   <= 1'b0;
                        unknown_sticky <= 1'b0;
                     end
`endif
                  end
               end
               default: bit_cnt <= '0;
            endcase
         end

         if (cs_fall) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            if (abort_now) begin
               frame_err_out <= 1'b1;
`ifdef SPI_STATUS_EN
               abort_sticky  <= 1'b1;
`endif
            end
         end else if (cs_rise && state == ST_IDLE) begin
            state   <= ST_CMD;
            bit_cnt <= '0;
`ifdef SPI_STATUS_EN
            rd_is_status <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_bmstu_spi_target.sv
// Directed, table-driven bench for bmstu_spi_target acting as a mode-0 SPI host
// at SCK = clk/8; status-read sequence runs only when SPI_STATUS_EN is defined.
module tb_bmstu_spi_target;

   localparam logic [31:0] RD_VAL = 32'hCAFEF00D;

   logic        clk;
   logic        rst_n;
   logic        sck;
   logic        cs;
   logic        copi;
   logic        cipo;
   logic        wr_en;
   logic [23:0] wr_address;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [23:0] rd_address;
   logic [31:0] rd_data;
   logic        frame_err;

   int unsigned n_wr = 0, n_rd = 0, n_err = 0;
   int unsigned n_checks = 0, n_errors = 0;

   typedef struct {
      logic [71:0] frame;
      int unsigned nbits;
      bit          simul;
      int unsigned exp_wr;
      int unsigned exp_rd;
      int unsigned exp_err;
      logic [23:0] exp_waddr;
      logic [31:0] exp_wdata;
      logic [23:0] exp_raddr;
      logic [71:0] exp_rx;
   } vec_t;

   vec_t vecs[$];

   bmstu_spi_target #(
      .CMD_W(8), .ADDR_W(24), .DATA_W(32), .DUMMY_W(8),
      .CMD_WRITE(8'h55), .CMD_READ(8'h0B), .CMD_STATUS(8'h05)
   ) dut (
      .clk_in(clk), .reset_in_neg(rst_n),
      .spi_sck_in(sck), .spi_cs_in(cs), .spi_copi_in(copi), .spi_cipo_out(cipo),
      .wr_en_out(wr_en), .wr_address_out(wr_address), .wr_data_out(wr_data),
      .rd_en_out(rd_en), .rd_address_out(rd_address), .rd_data_in(rd_data),
      .frame_err_out(frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: read data is valid only in the cycle after rd_en_out.
   always @(posedge clk) rd_data <= rd_en ? RD_VAL : 32'h0;

   always @(negedge clk) begin
      if (wr_en)     n_wr  <= n_wr + 1;
      if (rd_en)     n_rd  <= n_rd + 1;
      if (frame_err) n_err <= n_err + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d,
                                input int unsigned nb, input bit sim,
                                input int unsigned ew, input int unsigned er, input int unsigned ee,
                                input logic [23:0] wa, input logic [31:0] wd,
                                input logic [23:0] ra, input logic [71:0] rx);
      vec_t v;
      v.frame = {c, a, d, 8'h00};
      v.nbits = nb;  v.simul = sim;
      v.exp_wr = ew; v.exp_rd = er; v.exp_err = ee;
      v.exp_waddr = wa; v.exp_wdata = wd; v.exp_raddr = ra; v.exp_rx = rx;
      return v;
   endfunction

   // Host side: COPI changes with SCK low, CIPO is sampled on each SCK rise.
   task automatic send(input logic [71:0] frame, input int unsigned nbits, input bit simul,
                       input bit keep_cs, output logic [71:0] rx);
      rx = '0;
      cs = 1'b1;
      repeat (8) @(negedge clk);
      for (int unsigned i = 0; i < nbits; i++) begin
         copi = frame[71 - i];
         repeat (4) @(negedge clk);
         sck = 1'b1;
         if (simul && i == nbits - 1) cs = 1'b0;
         rx = {rx[70:0], cipo};
         repeat (4) @(negedge clk);
         sck = 1'b0;
      end
      copi = 1'b0;
      if (!keep_cs) begin
         repeat (4) @(negedge clk);
         cs = 1'b0;
         repeat (12) @(negedge clk);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int unsigned w0, r0, e0;
      logic [71:0] rx;
      w0 = n_wr; r0 = n_rd; e0 = n_err;
      send(v.frame, v.nbits, v.simul, 1'b0, rx);
      chk($sformatf("v%0d_wr_strobes", idx), 72'(n_wr - w0), 72'(v.exp_wr));
      chk($sformatf("v%0d_rd_strobes", idx), 72'(n_rd - r0), 72'(v.exp_rd));
      chk($sformatf("v%0d_frame_err", idx), 72'(n_err - e0), 72'(v.exp_err));
      chk($sformatf("v%0d_wr_address", idx), 72'(wr_address), 72'(v.exp_waddr));
      chk($sformatf("v%0d_wr_data", idx), 72'(wr_data), 72'(v.exp_wdata));
      chk($sformatf("v%0d_rd_address", idx), 72'(rd_address), 72'(v.exp_raddr));
      chk($sformatf("v%0d_cipo_bits", idx), rx, v.exp_rx);
   endtask

   initial begin
      logic [71:0] rx;
      rst_n = 1'b0; sck = 1'b0; cs = 1'b0; copi = 1'b0;
      repeat (4) @(negedge clk);
      chk("reset_wr_outputs", 72'({wr_en, wr_address, wr_data}), '0);
      chk("reset_rd_outputs", 72'({cipo, rd_en, rd_address, frame_err}), '0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      vecs.push_back(mkv(8'h55, 24'h123456, 32'hDEADBEEF, 64, 0, 1, 0, 0,
                         24'h123456, 32'hDEADBEEF, 24'h000000, 72'h0));
      vecs.push_back(mkv(8'h0B, 24'h00ABCD, 32'h0, 72, 0, 0, 1, 0,
                         24'h123456, 32'hDEADBEEF, 24'h00ABCD, {40'h0, 32'hCAFEF00D}));
      vecs.push_back(mkv(8'h55, 24'h654321, 32'hFFFFFFFF, 52, 0, 0, 0, 1,
                         24'h123456, 32'hDEADBEEF, 24'h00ABCD, 72'h0));
      vecs.push_back(mkv(8'h55, 24'h000001, 32'h00000002, 64, 0, 1, 0, 0,
                         24'h000001, 32'h00000002, 24'h00ABCD, 72'h0));
      vecs.push_back(mkv(8'h77, 24'hFFFFFF, 32'hFFFFFFFF, 64, 0, 0, 0, 1,
                         24'h000001, 32'h00000002, 24'h00ABCD, 72'h0));
      vecs.push_back(mkv(8'h0B, 24'h000010, 32'h0, 36, 0, 0, 1, 1,
                         24'h000001, 32'h00000002, 24'h000010, 72'h0));
      vecs.push_back(mkv(8'h55, 24'h00FF00, 32'h12345678, 72, 0, 1, 0, 0,
                         24'h00FF00, 32'h12345678, 24'h000010, 72'h0));
      vecs.push_back(mkv(8'h55, 24'h0A0B0C, 32'h11223344, 64, 1, 1, 0, 0,
                         24'h0A0B0C, 32'h11223344, 24'h000010, 72'h0));
`ifndef SPI_STATUS_EN
      vecs.push_back(mkv(8'h05, 24'h0, 32'h0, 64, 0, 0, 0, 1,
                         24'h0A0B0C, 32'h11223344, 24'h000010, 72'h0));
`endif

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Reset while the frame is in its address phase.
      send({8'h55, 24'h777777, 32'h0, 8'h00}, 20, 1'b0, 1'b1, rx);
      rst_n = 1'b0;
      #1;
      chk("midreset_wr_outputs", 72'({wr_en, wr_address, wr_data}), '0);
      chk("midreset_rd_outputs", 72'({cipo, rd_en, rd_address, frame_err}), '0);
      @(negedge clk);
      cs = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      run_vec(mkv(8'h55, 24'hABCDEF, 32'h01020304, 64, 0, 1, 0, 0,
                  24'hABCDEF, 32'h01020304, 24'h000000, 72'h0), 100);

`ifdef SPI_STATUS_EN
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      for (int unsigned i = 1; i <= 3; i++)
         run_vec(mkv(8'h55, 24'(i), 32'(i), 64, 0, 1, 0, 0,
                     24'(i), 32'(i), 24'h000000, 72'h0), 200 + int'(i));
      run_vec(mkv(8'h55, 24'h000009, 32'h9, 52, 0, 0, 0, 1,
                  24'h000003, 32'h3, 24'h000000, 72'h0), 210);
      run_vec(mkv(8'h05, 24'h0, 32'h0, 24, 0, 0, 0, 0,
                  24'h000003, 32'h3, 24'h000000, 72'h83), 211);
      run_vec(mkv(8'h05, 24'h0, 32'h0, 24, 0, 0, 0, 0,
                  24'h000003, 32'h3, 24'h000000, 72'h03), 212);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
